// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared branch-predictor types and defaults so that the GHR,
//                the checkpoint queue and the PHT agree on history width.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

    localparam int c_GHR_WIDTH = 8;
    localparam int c_DEPTH     = 8;

    typedef logic [c_GHR_WIDTH-1:0]     ghr_t;
    typedef logic [$clog2(c_DEPTH)-1:0] ckpt_ptr_t;

    // Shift one resolved/predicted outcome into the youngest history bit.
    function automatic ghr_t ghr_shift(input ghr_t ghr, input logic outcome);
        return {ghr[c_GHR_WIDTH-2:0], outcome};
    endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/ghr_ckpt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ghr_ckpt_fifo
//  Description : Circular checkpoint buffer. Push appends at the write
//                pointer, pop retires the head, flush (normally issued with a
//                pop) discards every younger entry. Entry storage is not
//                cleared; stale entries simply persist until overwritten.
//  Revision    : 1.0  initial release
// ============================================================================
module ghr_ckpt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A flush cancels any same-cycle push: that push is on the wrong path.
    assign w_push   = i_push & ~w_full & ~i_flush;
    assign w_pop    = i_pop & ~w_empty;
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;

    // Checkpoint storage: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a flush collapses the queue onto
    // the slot just past the retiring head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (i_flush) begin
                r_wr_ptr <= w_rd_ptr_nxt;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule : ghr_ckpt_fifo
`default_nettype wire

// File: rtl/ghr_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ghr_ckpt_ctrl
//  Description : Speculative global-history controller. Shifts IF1
//                predictions into spec_ghr, checkpoints the pre-prediction
//                history, retires checkpoints in order on EX resolution to
//                drive the PHT update port, and restores spec_ghr on a
//                mispredict while flushing all younger checkpoints.
//  Revision    : 1.0  initial release
// ============================================================================
module ghr_ckpt_ctrl
    import bp_pkg::*;
#(
    parameter int GHR_WIDTH = c_GHR_WIDTH,
    parameter int DEPTH     = c_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if1_valid,
    input  logic                    if1_pred,
    output logic                    if1_ready,
    input  logic                    ex_valid,
    input  logic                    ex_branched,
    input  logic                    ex_mispred,
    output logic [GHR_WIDTH-1:0]    spec_ghr,
    output logic [GHR_WIDTH-1:0]    arch_ghr,
    output logic                    pht_we,
    output logic                    pht_branched,
    output logic [GHR_WIDTH-1:0]    pht_ghr,
    output logic                    recover,
    output logic [$clog2(DEPTH):0]  ckpt_count
);

    logic [GHR_WIDTH-1:0] r_spec_ghr;
    logic [GHR_WIDTH-1:0] r_arch_ghr;
    logic [GHR_WIDTH-1:0] r_pht_ghr;
    logic                 r_pht_we;
    logic                 r_pht_branched;
    logic                 r_recover;

    logic [GHR_WIDTH-1:0] w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_restore;
    logic                 w_push;

    // A resolution against an empty queue is a protocol violation and is
    // dropped here so it cannot disturb any state.
    assign w_pop     = ex_valid & ~w_empty;
    assign w_restore = w_pop & ex_mispred;
    // Readiness looks only at the registered count: a full queue refuses a
    // push even when a pop retires an entry in the same cycle.
    assign w_push    = if1_valid & ~w_full & ~w_restore;

    ghr_ckpt_fifo #(
        .WIDTH (GHR_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_spec_ghr),
        .i_pop       (w_pop),
        .i_flush     (w_restore),
        .o_head_data (w_head),
        .o_count     (ckpt_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Speculative history: restore from the mispredicting checkpoint with the
    // real outcome appended, otherwise shift in each accepted prediction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spec_ghr <= '0;
        end else if (w_restore) begin
            r_spec_ghr <= {w_head[GHR_WIDTH-2:0], ex_branched};
        end else if (w_push) begin
            r_spec_ghr <= {r_spec_ghr[GHR_WIDTH-2:0], if1_pred};
        end
    end

    // Architectural history advances by one resolved outcome per retirement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arch_ghr <= '0;
        end else if (w_pop) begin
            r_arch_ghr <= {r_arch_ghr[GHR_WIDTH-2:0], ex_branched};
        end
    end

    // PHT update port: strobes are single-cycle pulses, data holds between
    // retirements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pht_we       <= 1'b0;
            r_pht_branched <= 1'b0;
            r_pht_ghr      <= '0;
            r_recover      <= 1'b0;
        end else begin
            r_pht_we  <= w_pop;
            r_recover <= w_restore;
            if (w_pop) begin
                r_pht_branched <= ex_branched;
                r_pht_ghr      <= w_head;
            end
        end
    end

    assign if1_ready    = ~w_full;
    assign spec_ghr     = r_spec_ghr;
    assign arch_ghr     = r_arch_ghr;
    assign pht_we       = r_pht_we;
    assign pht_branched = r_pht_branched;
    assign pht_ghr      = r_pht_ghr;
    assign recover      = r_recover;

endmodule : ghr_ckpt_ctrl
`default_nettype wire

// File: doc/ghr_ckpt_ctrl.md
# ghr_ckpt_ctrl

Speculative global-history controller for the IF1 branch predictor. Shifts each IF1 prediction into a speculative GHR. Checkpoints the pre-prediction history in a circular queue. Retires checkpoints in order as branches resolve in EX, and drives the PHT/GHR update port with the history that was used at prediction time. On a mispredict it restores the speculative GHR from the checkpoint and flushes all younger in-flight checkpoints.

## Interface
- GHR_WIDTH, 8, history length in bits
- DEPTH, 8, maximum in-flight predicted branches (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if1_valid  in  1  IF1 predicts a conditional branch this cycle
- if1_pred  in  1  predicted direction (1 = taken)
- if1_ready  out  1  checkpoint queue not full; push accepted only when if1_valid & if1_ready
- ex_valid  in  1  oldest in-flight branch resolves this cycle
- ex_branched  in  1  actual direction
- ex_mispred  in  1  prediction was wrong (qualified by ex_valid)
- spec_ghr  out  GHR_WIDTH  speculative history, used for IF1 PHT indexing
- arch_ghr  out  GHR_WIDTH  resolved (non-speculative) history
- pht_we  out  1  registered PHT update strobe
- pht_branched  out  1  outcome for the update
- pht_ghr  out  GHR_WIDTH  history snapshot used for the resolving branch's prediction
- recover  out  1  one-cycle pulse: a mispredict restore occurred
- ckpt_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Queue entry = spec_ghr value before the prediction was shifted in. Pointers are wr_ptr/rd_ptr mod DEPTH, and count ranges 0..DEPTH.
- Push (if1_valid & if1_ready & no restore this cycle):
  - entry[wr_ptr] ← spec_ghr
  - spec_ghr ← {spec_ghr[W-2:0], if1_pred}
  - wr_ptr++
- Pop (ex_valid & count≠0):
  - arch_ghr ← {arch_ghr[W-2:0], ex_branched}
  - pht_ghr ← entry[rd_ptr]
  - pht_branched ← ex_branched
  - pht_we ← 1
  - rd_ptr++
- Restore (pop & ex_mispred):
  - spec_ghr ← {entry[rd_ptr][W-2:0], ex_branched}
  - Queue flushed: wr_ptr ← rd_ptr+1, count ← 0.
  - A same-cycle IF1 push is discarded (wrong path), and spec_ghr does not take if1_pred.
  - recover ← 1
- Push and pop in the same cycle without mispredict: both occur and count is unchanged. The push snapshots the pre-update spec_ghr.
- if1_ready = (count ≠ DEPTH). No same-cycle pop bypass: a full queue rejects the push even if a pop occurs.
- ex_valid with count = 0 is a protocol violation. It is ignored: no state change, no pht_we, no recover.
- Pointer wrap-around at DEPTH is transparent. Entries persist until overwritten.
- Invariant with no mispredict outstanding: entry[rd_ptr] equals arch_ghr.

## Timing
- Reset values (sampled on clk when rst_n=0):
  - spec_ghr, arch_ghr, pht_ghr = 0
  - pht_we, pht_branched, recover = 0
  - ckpt_count = 0, pointers = 0
  - if1_ready = 1
- Reset mid-operation discards all checkpoints, and no pht_we follows the reset edge.
- spec_ghr updates on the edge after an accepted push, so the next IF1 lookup sees it.
- pht_we / pht_branched / pht_ghr: registered, valid exactly one cycle after ex_valid. pht_we is a single-cycle pulse per pop.
- recover: one cycle, coincident with the pht_we of the mispredicting branch. spec_ghr is already restored in that cycle.
- if1_ready is a combinational function of the registered count only.

## Structure
- Shared package bp_pkg:
  - GHR_WIDTH default
  - ghr_t (logic [GHR_WIDTH-1:0])
  - ckpt_ptr_t
  - Shared with the GHR/PHT predictor so history widths agree.
- Sub-module ghr_ckpt_fifo holds the circular buffer:
  - push/pop/flush interface
  - head data output
  - count/full/empty outputs
- The top level holds spec_ghr, arch_ghr, the update registers and the restore logic.

## Test plan
All cases use GHR_WIDTH=8, DEPTH=8.
- Reset: hold rst_n=0 for 2 cycles → spec_ghr=arch_ghr=8'h00, ckpt_count=0, if1_ready=1, pht_we=0, recover=0.
- Push preds 1,0,1 on consecutive cycles → spec_ghr=8'h05, ckpt_count=3, stored entries 8'h00, 8'h01, 8'h02.
- Then ex_valid, ex_branched=1, ex_mispred=0 → next cycle pht_we=1, pht_ghr=8'h00, pht_branched=1, arch_ghr=8'h01, ckpt_count=2.
- Then ex_valid, ex_branched=1, ex_mispred=1, with a simultaneous if1_valid, if1_pred=1 → next cycle:
  - pht_ghr=8'h01, arch_ghr=8'h03, spec_ghr=8'h03
  - ckpt_count=0, recover=1
  - the push is discarded.
- Fill 8 pushes → if1_ready=0. A 9th push is rejected, and spec_ghr is unchanged. Pop plus push at count 7 → count stays 7. Pointers wrap past entry 7 correctly across 20 push/pop pairs.
- ex_valid with empty queue → no pht_we, no state change. rst_n=0 at ckpt_count=5 → all outputs at reset values next cycle, and no pht_we.
